// File: rtl/block_sf_48_dematrix.sv
// block_sf_48_dematrix
// Receive-side stereo de-matrix: takes one L+R / L-R sample pair, scales each
// by a 4-bit gain (value G/8) with a 4-cycle LSB-first shift-add multiplier,
// then recovers LEFT = (S+D+8)>>>4 and RIGHT = (S-D+8)>>>4.
//
// Handshake: a transfer is accepted on a rising edge where start = 1 and
// ready = 1. ready is high only in IDLE, so start is ignored while busy.
// Results appear 5 edges after accept together with a one-cycle ready_out
// strobe; LEFT/RIGHT hold their value between strobes.
//
// Optional feature macro: DEMATRIX_SAT_EN
//   defined   : results saturate to [-131072, 131071], sat_flag marks clipping
//   undefined : results wrap to 18 bits, sat_flag is constant 0
//
// dbg_state exposes the FSM encoding (0 = IDLE, 1 = MUL, 2 = OUT).
module block_sf_48_dematrix (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [17:0] LpR,
  input  logic signed [17:0] LmR,
  input  logic        [3:0]  Gs,
  input  logic        [3:0]  Gd,
  input  logic               start,
  output logic               ready,
  output logic signed [17:0] LEFT,
  output logic signed [17:0] RIGHT,
  output logic               ready_out,
  output logic               sat_flag,
  output logic        [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [17:0] lpr_q;
  logic signed [17:0] lmr_q;
  logic        [3:0]  gs_q;
  logic        [3:0]  gd_q;
  logic signed [21:0] acc_s;
  logic signed [21:0] acc_d;
  logic        [1:0]  bit_idx;

  logic signed [21:0] lpr_ext;
  logic signed [21:0] lmr_ext;
  logic signed [22:0] sum_w;
  logic signed [22:0] diff_w;
  logic signed [18:0] left_19;
  logic signed [18:0] right_19;
  logic signed [17:0] left_clip;
  logic signed [17:0] right_clip;
  logic               clip_any;
  logic               unused_lsbs;

  assign lpr_ext = {{4{lpr_q[17]}}, lpr_q};
  assign lmr_ext = {{4{lmr_q[17]}}, lmr_q};

  // Round half up: add 8 at full 23-bit width, then keep bits [22:4]
  assign sum_w    = {acc_s[21], acc_s} + {acc_d[21], acc_d} + 23'sd8;
  assign diff_w   = {acc_s[21], acc_s} - {acc_d[21], acc_d} + 23'sd8;
  assign left_19  = sum_w[22:4];
  assign right_19 = diff_w[22:4];

`ifdef DEMATRIX_SAT_EN
  logic left_ovf;
  logic right_ovf;

  // A 19-bit value fits in 18 bits exactly when its top two bits agree
  always_comb begin
    left_ovf   = left_19[18] ^ left_19[17];
    right_ovf  = right_19[18] ^ right_19[17];
    left_clip  = left_ovf  ? (left_19[18]  ? 18'sh20000 : 18'sh1FFFF) : left_19[17:0];
    right_clip = right_ovf ? (right_19[18] ? 18'sh20000 : 18'sh1FFFF) : right_19[17:0];
    clip_any   = left_ovf | right_ovf;
  end

  assign unused_lsbs = ^{sum_w[3:0], diff_w[3:0]};
`else
  // Two's-complement wrap: the extra top bit is simply dropped
  always_comb begin
    left_clip  = left_19[17:0];
    right_clip = right_19[17:0];
    clip_any   = 1'b0;
  end

  assign unused_lsbs = ^{sum_w[3:0], diff_w[3:0], left_19[18], right_19[18]};
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> MUL on start, 4 MUL cycles, one OUT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_MUL;
      ST_MUL:  if (bit_idx == 2'd3) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    ready     = (state == ST_IDLE);
    dbg_state = state;
  end

  // Capture operands on accept, then add one shifted partial product per cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lpr_q   <= '0;
      lmr_q   <= '0;
      gs_q    <= '0;
      gd_q    <= '0;
      acc_s   <= '0;
      acc_d   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lpr_q   <= LpR;
            lmr_q   <= LmR;
            gs_q    <= Gs;
            gd_q    <= Gd;
            acc_s   <= '0;
            acc_d   <= '0;
            bit_idx <= '0;
          end
        end
        ST_MUL: begin
          if (gs_q[bit_idx]) acc_s <= acc_s + (lpr_ext <<< bit_idx);
          if (gd_q[bit_idx]) acc_d <= acc_d + (lmr_ext <<< bit_idx);
          bit_idx <= bit_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Register results and raise the one-cycle strobes in the OUT cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      LEFT      <= '0;
      RIGHT     <= '0;
      ready_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (state == ST_OUT) begin
      LEFT      <= left_clip;
      RIGHT     <= right_clip;
      ready_out <= 1'b1;
      sat_flag  <= clip_any;
    end else begin
      ready_out <= 1'b0;
      sat_flag  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_sf_48_dematrix.sv
// tb_block_sf_48_dematrix
// Directed bench for the stereo de-matrix. Expected LEFT/RIGHT/sat values come
// from an integer model and are queued at accept time; a negedge monitor pops
// and compares on every ready_out strobe.
// Honours DEMATRIX_SAT_EN the same way the design does.
module tb_block_sf_48_dematrix;

  logic               clock;
  logic               reset;
  logic signed [17:0] LpR;
  logic signed [17:0] LmR;
  logic        [3:0]  Gs;
  logic        [3:0]  Gd;
  logic               start;
  logic               ready;
  logic signed [17:0] LEFT;
  logic signed [17:0] RIGHT;
  logic               ready_out;
  logic               sat_flag;
  logic        [1:0]  dbg_state;

  // {LEFT[17:0], RIGHT[17:0], sat}
  logic [36:0] exp_q[$];

  int n_cmp;
  int n_err;
  int n_strobe;

  block_sf_48_dematrix dut (
    .clock     (clock),
    .reset     (reset),
    .LpR       (LpR),
    .LmR       (LmR),
    .Gs        (Gs),
    .Gd        (Gd),
    .start     (start),
    .ready     (ready),
    .LEFT      (LEFT),
    .RIGHT     (RIGHT),
    .ready_out (ready_out),
    .sat_flag  (sat_flag),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic logic [36:0] model(input int a, input int b, input int gs, input int gd);
    int s, d, l, r;
    logic sl, sr;
    logic [17:0] lo, ro;
    s = a * gs;
    d = b * gd;
    l = (s + d + 8) >>> 4;
    r = (s - d + 8) >>> 4;
    sl = 1'b0;
    sr = 1'b0;
`ifdef DEMATRIX_SAT_EN
    if (l > 131071) begin l = 131071; sl = 1'b1; end
    else if (l < -131072) begin l = -131072; sl = 1'b1; end
    if (r > 131071) begin r = 131071; sr = 1'b1; end
    else if (r < -131072) begin r = -131072; sr = 1'b1; end
`endif
    lo = l[17:0];
    ro = r[17:0];
    return {lo, ro, sl | sr};
  endfunction

  // Driver: wait for ready, present one pair for one edge, then scramble inputs
  task automatic send(input int a, input int b, input int gs, input int gd);
    int guard;
    logic [31:0] ta, tb, tg1, tg2;
    guard = 0;
    @(negedge clock);
    while (!ready && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    ta = a; tb = b; tg1 = gs; tg2 = gd;
    LpR   = ta[17:0];
    LmR   = tb[17:0];
    Gs    = tg1[3:0];
    Gd    = tg2[3:0];
    start = 1'b1;
    exp_q.push_back(model(a, b, gs, gd));
    @(posedge clock);
    #1;
    start = 1'b0;
    LpR   = 18'($urandom);
    LmR   = 18'($urandom);
    Gs    = 4'($urandom);
    Gd    = 4'($urandom);
  endtask

  // Wait until every queued expectation has been compared
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: compare every strobe against the head of the expected queue
  always @(negedge clock) begin
    if (reset && ready_out) begin
      logic [36:0] e;
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("stray_ready_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("LEFT",     {46'd0, LEFT},  {46'd0, e[36:19]});
        check("RIGHT",    {46'd0, RIGHT}, {46'd0, e[18:1]});
        check("sat_flag", 64'(sat_flag),  64'(e[0]));
      end
    end
    if (reset && sat_flag && !ready_out) check("sat_without_strobe", 64'd1, 64'd0);
  end

  initial begin
    int strobe_base;
    int a, b;
    logic [36:0] e;
    n_cmp = 0;
    n_err = 0;
    n_strobe = 0;
    reset = 1'b0;
    start = 1'b0;
    LpR = '0; LmR = '0; Gs = '0; Gd = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready",     64'(ready),     64'd1);
    check("rst_ready_out", 64'(ready_out), 64'd0);
    check("rst_sat",       64'(sat_flag),  64'd0);
    check("rst_left",      {46'd0, LEFT},  64'd0);
    check("rst_right",     {46'd0, RIGHT}, 64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    reset = 1'b1;

    // Round trip with latency / ready profile: accept at N, strobe at N+5
    send(47, -17, 8, 8);
    check("busy_after_accept", 64'(ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      check("busy_ready", 64'(ready), 64'd0);
      check("busy_strobe", 64'(ready_out), 64'd0);
    end
    @(posedge clock); #1;
    check("done_strobe", 64'(ready_out), 64'd1);
    check("done_ready",  64'(ready),     64'd1);
    e = model(47, -17, 8, 8);
    check("rt_model_left",  {46'd0, LEFT},  {46'd0, e[36:19]});
    check("rt_left_const",  {46'd0, LEFT},  {46'd0, 18'd15});
    check("rt_right_const", {46'd0, RIGHT}, {46'd0, 18'd32});
    @(posedge clock); #1;
    check("strobe_one_cycle", 64'(ready_out), 64'd0);
    drain("drain_rt");

    // Rounding, gain corners and overflow in both directions
    send(1, 0, 8, 8);
    send(-1, 0, 8, 8);
    send(131071, 131071, 15, 15);
    send(-131072, -131072, 15, 15);
    send(131071, -131072, 15, 15);
    send(12345, -6789, 0, 15);
    send(-100000, 99999, 15, 0);
    send(0, 0, 0, 0);
    drain("drain_corners");

    // Random operands
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(262143)) - 131072;
      b = int'($urandom_range(262143)) - 131072;
      send(a, b, int'($urandom_range(15)), int'($urandom_range(15)));
    end
    drain("drain_random");

    // start held high with inputs changing every cycle: accepts at N, N+6, N+12
    @(negedge clock);
    strobe_base = n_strobe;
    for (int c = 0; c < 18; c++) begin
      a = int'($urandom_range(262143)) - 131072;
      b = int'($urandom_range(262143)) - 131072;
      LpR = 18'(a);
      LmR = 18'(b);
      Gs  = 4'($urandom);
      Gd  = 4'($urandom);
      start = 1'b1;
      check("hold_ready", 64'(ready), 64'((c % 6) == 0));
      if ((c % 6) == 0) exp_q.push_back(model(a, b, int'(Gs), int'(Gd)));
      @(negedge clock);
    end
    start = 1'b0;
    drain("drain_hold");
    check("hold_strobes", 64'(n_strobe - strobe_base), 64'd3);

    // Abort: reset at N+3 of an operation, no strobe afterwards
    strobe_base = n_strobe;
    send(5000, 3000, 9, 7);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready",  64'(ready),     64'd1);
    check("abort_strobe", 64'(ready_out), 64'd0);
    check("abort_left",   {46'd0, LEFT},  64'd0);
    check("abort_right",  {46'd0, RIGHT}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("abort_no_strobe", 64'(n_strobe - strobe_base), 64'd0);
    send(-2222, 777, 11, 5);
    drain("drain_after_abort");
    check("after_abort_strobes", 64'(n_strobe - strobe_base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
